// File: rtl/act_row_injector.sv
// act_row_injector: west-edge activation source for one systolic-array row.
// Buffers activation beats in a small FIFO and drives each with a per-column valid vector.
module act_row_injector #(
    parameter int NUM_COLS   = 4,
    parameter int ACT_BIT    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_BIT    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ACT_BIT-1:0]          in_data,
    input  logic [$clog2(NUM_COLS)-1:0] in_col,
    input  logic [1:0]                  in_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ACT_BIT-1:0]          out_data,
    output logic [NUM_COLS-1:0]         out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_pulse,
    output logic [CNT_BIT-1:0]          beats_sent
);

    localparam int COL_W  = $clog2(NUM_COLS);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [1:0] MODE_UNI   = 2'b00;
    localparam logic [1:0] MODE_BCAST = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;
    localparam logic [1:0] MODE_ILL   = 2'b11;

    typedef enum logic {IDLE, SEND} state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [ACT_BIT-1:0] mem_data [FIFO_DEPTH];
    logic [COL_W-1:0]   mem_col  [FIFO_DEPTH];
    logic [1:0]         mem_mode [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, illegal, write_en, pop, fifo_empty;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign in_ready   = (fifo_count != PTR_W'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;

    // Broadcast ignores the column; unicast and sweep need a real start column.
    assign illegal  = (in_mode == MODE_ILL) ||
                      ((in_mode != MODE_BCAST) && (int'(in_col) >= NUM_COLS));
    assign write_en = push && !illegal;

    // NOTE: storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_data[wr_ptr[ADDR_W-1:0]] <= in_data;
            mem_col[wr_ptr[ADDR_W-1:0]]  <= in_col;
            mem_mode[wr_ptr[ADDR_W-1:0]] <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= push && illegal;
            if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output sequencer
    // ------------------------------------------------------------------
    state_e           state;
    logic [1:0]       cur_mode;
    logic [COL_W-1:0] cur_col;
    logic             transfer, beat_done;

    logic [ACT_BIT-1:0] head_data;
    logic [COL_W-1:0]   head_col;
    logic [1:0]         head_mode;

    assign head_data = mem_data[rd_ptr[ADDR_W-1:0]];
    assign head_col  = mem_col[rd_ptr[ADDR_W-1:0]];
    assign head_mode = mem_mode[rd_ptr[ADDR_W-1:0]];

    function automatic logic [NUM_COLS-1:0] valid_vec(input logic [1:0]       mode,
                                                      input logic [COL_W-1:0] col);
        if (mode == MODE_BCAST) return '1;
        return NUM_COLS'(1) << col;
    endfunction

    assign transfer  = (|out_valid) && out_ready;
    assign beat_done = (cur_mode != MODE_SWEEP) || (cur_col == COL_W'(NUM_COLS - 1));
    // A finished beat is replaced in the same cycle, so back-to-back beats have no bubble.
    assign pop       = !fifo_empty && ((state == IDLE) || (transfer && beat_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_data   <= '0;
            out_valid  <= '0;
            cur_mode   <= MODE_UNI;
            cur_col    <= '0;
            beats_sent <= '0;
        end else begin
            if (transfer) beats_sent <= beats_sent + CNT_BIT'(1);
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        out_data  <= head_data;
                        out_valid <= valid_vec(head_mode, head_col);
                        cur_mode  <= head_mode;
                        cur_col   <= head_col;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        if (!beat_done) begin
                            cur_col   <= cur_col + COL_W'(1);
                            out_valid <= out_valid << 1;
                        end else if (!fifo_empty) begin
                            out_data  <= head_data;
                            out_valid <= valid_vec(head_mode, head_col);
                            cur_mode  <= head_mode;
                            cur_col   <= head_col;
                        end else begin
                            out_valid <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
